// File: rtl/fifo_deq_serializer.sv
// Pops wide words from an upstream FIFO and pushes them into a downstream FIFO
// as `lanes` narrow beats, reloading on the last beat so there is no bubble.
module fifo_deq_serializer #(
    parameter int in_width  = 32,
    parameter int lanes     = 4,
    parameter bit msb_first = 1'b0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CLR,
    input  logic                      EMPTY_N,
    input  logic [in_width-1:0]       D_IN,
    output logic                      DEQ,
    input  logic                      FULL_N,
    output logic [in_width/lanes-1:0] D_OUT,
    output logic                      ENQ,
    output logic                      LAST,
    output logic                      BUSY
);

    localparam int W     = in_width / lanes;
    localparam int CNT_W = (lanes > 1) ? $clog2(lanes) : 1;
    localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(lanes - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [in_width-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]    lane_sel;
    logic                valid;
    logic                enq, last, deq;

    assign valid = (state_q == SEND);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // DEQ is gated by RST so nothing is popped while the block is held in reset.
    always_comb begin
        enq     = valid & FULL_N & ~CLR;
        last    = enq & (cnt_q == LANE_LAST);
        deq     = RST & EMPTY_N & ~CLR & (~valid | last);
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        if (CLR) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (deq) begin
            hold_d  = D_IN;
            state_d = SEND;
            cnt_d   = '0;
        end else if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (enq) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        lane_sel = msb_first ? (LANE_LAST - cnt_q) : cnt_q;
        D_OUT    = '0;
        for (int k = 0; k < lanes; k++) begin
            if (lane_sel == CNT_W'(k)) begin
                D_OUT = hold_q[k*W +: W];
            end
        end
    end

    assign DEQ  = deq;
    assign ENQ  = enq;
    assign LAST = last;
    assign BUSY = valid;

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Directed bench: stimulus pushes expected beats into a scoreboard queue and
// negedge monitors pop and compare whenever a DUT presents ENQ.
module tb_fifo_deq_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, empty_n, full_n;
    logic [31:0] d_in;
    logic        deq, enq, last, busy;
    logic [7:0]  d_out;

    logic        m_empty_n;
    logic [31:0] m_d_in;
    logic        m_deq, m_enq, m_last, m_busy;
    logic [7:0]  m_d_out;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] mexp_q[$];

    int deq_cnt = 0, busy_cnt = 0, enq_cnt = 0, dl_cnt = 0;
    int run = 0, max_run = 0;

    always #5 clk = ~clk;

    fifo_deq_serializer #(.in_width(32), .lanes(4), .msb_first(1'b0)) dut (
        .CLK(clk), .RST(rst_n), .CLR(clr), .EMPTY_N(empty_n), .D_IN(d_in),
        .DEQ(deq), .FULL_N(full_n), .D_OUT(d_out), .ENQ(enq), .LAST(last), .BUSY(busy)
    );

    fifo_deq_serializer #(.in_width(32), .lanes(4), .msb_first(1'b1)) dut_msb (
        .CLK(clk), .RST(rst_n), .CLR(1'b0), .EMPTY_N(m_empty_n), .D_IN(m_d_in),
        .DEQ(m_deq), .FULL_N(1'b1), .D_OUT(m_d_out), .ENQ(m_enq), .LAST(m_last), .BUSY(m_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e_n, input logic [31:0] din, input logic f_n, input logic c);
        empty_n = e_n;
        d_in    = din;
        full_n  = f_n;
        clr     = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats of a word, LSB lane first, LAST on lane 3; only the first n are kept.
    task automatic pushWord(input logic [31:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({(k == 3), w[k*8 +: 8]});
        end
    endtask

    initial begin : monitor_main
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (deq) deq_cnt++;
            if (busy) busy_cnt++;
            if (deq && last) dl_cnt++;
            if (enq) begin
                enq_cnt++;
                run++;
                if (run > max_run) max_run = run;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_enq: got beat 0x%0h, expected no beat", d_out);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat_data", 32'(d_out), 32'(e[7:0]));
                    checkOutput("beat_last", 32'(last), 32'(e[8]));
                end
            end else begin
                run = 0;
                checkOutput("last_without_enq", 32'(last), 32'd0);
            end
        end
    end

    initial begin : monitor_msb
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (m_enq) begin
                if (mexp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL msb_unexpected_enq: got beat 0x%0h, expected no beat", m_d_out);
                end else begin
                    e = mexp_q.pop_front();
                    checkOutput("msb_beat_data", 32'(m_d_out), 32'(e[7:0]));
                    checkOutput("msb_beat_last", 32'(m_last), 32'(e[8]));
                end
            end
        end
    end

    initial begin : stimulus
        int b_deq, b_busy, b_enq, b_dl;
        rst_n     = 1'b0;
        m_empty_n = 1'b0;
        m_d_in    = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        #3;
        checkOutput("reset_deq",   32'(deq),   32'd0);
        checkOutput("reset_enq",   32'(enq),   32'd0);
        checkOutput("reset_last",  32'(last),  32'd0);
        checkOutput("reset_busy",  32'(busy),  32'd0);
        checkOutput("reset_d_out", 32'(d_out), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("[TB] single word");
        b_deq = deq_cnt; b_busy = busy_cnt;
        pushWord(32'hDDCCBBAA, 4);
        applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("single_deq", 32'(deq), 32'd1);
        tick();
        empty_n = 1'b0;
        repeat (6) tick();
        checkOutput("single_deq_count",  32'(deq_cnt - b_deq),   32'd1);
        checkOutput("single_busy_count", 32'(busy_cnt - b_busy), 32'd4);

        $display("[TB] back-to-back words");
        b_deq = deq_cnt; b_enq = enq_cnt; b_dl = dl_cnt;
        pushWord(32'h03020100, 4);
        applyStimulus(1'b1, 32'h03020100, 1'b1, 1'b0);
        tick();
        pushWord(32'h07060504, 4);
        d_in = 32'h07060504;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reload_deq",  32'(deq),  32'd1);
        checkOutput("reload_last", 32'(last), 32'd1);
        tick();
        empty_n = 1'b0;
        repeat (6) tick();
        checkOutput("b2b_deq_count",      32'(deq_cnt - b_deq), 32'd2);
        checkOutput("b2b_deq_with_last",  32'(dl_cnt - b_dl),   32'd1);
        checkOutput("b2b_enq_count",      32'(enq_cnt - b_enq), 32'd8);
        checkOutput("b2b_max_run",        32'(max_run),         32'd8);

        $display("[TB] backpressure");
        b_deq = deq_cnt;
        pushWord(32'hDDCCBBAA, 4);
        applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0);
        tick();
        pushWord(32'h0B0A0908, 4);
        d_in = 32'h0B0A0908;
        repeat (2) tick();
        full_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_enq",   32'(enq),   32'd0);
            checkOutput("bp_d_out", 32'(d_out), 32'hCC);
            checkOutput("bp_deq",   32'(deq),   32'd0);
            tick();
        end
        full_n = 1'b1;
        repeat (2) tick();
        empty_n = 1'b0;
        repeat (6) tick();
        checkOutput("bp_deq_count", 32'(deq_cnt - b_deq), 32'd2);

        $display("[TB] clear");
        pushWord(32'hDDCCBBAA, 1);
        applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0);
        tick();
        d_in = 32'h88776655;
        tick();
        clr = 1'b1;
        pushWord(32'h88776655, 4);
        @(negedge clk);
        checkOutput("clr_enq", 32'(enq), 32'd0);
        checkOutput("clr_deq", 32'(deq), 32'd0);
        tick();
        clr = 1'b0;
        @(negedge clk);
        checkOutput("clr_busy_after", 32'(busy), 32'd0);
        checkOutput("clr_next_deq",   32'(deq),  32'd1);
        tick();
        empty_n = 1'b0;
        repeat (6) tick();

        $display("[TB] reset mid-word");
        pushWord(32'h44332211, 1);
        applyStimulus(1'b1, 32'h44332211, 1'b1, 1'b0);
        tick();
        d_in = 32'h0F0E0D0C;
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_deq",   32'(deq),   32'd0);
        checkOutput("rst_enq",   32'(enq),   32'd0);
        checkOutput("rst_last",  32'(last),  32'd0);
        checkOutput("rst_busy",  32'(busy),  32'd0);
        checkOutput("rst_d_out", 32'(d_out), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        pushWord(32'h0F0E0D0C, 4);
        @(negedge clk);
        checkOutput("rst_release_deq", 32'(deq), 32'd1);
        tick();
        empty_n = 1'b0;
        repeat (6) tick();

        $display("[TB] msb first");
        mexp_q.push_back({1'b0, 8'hDD});
        mexp_q.push_back({1'b0, 8'hCC});
        mexp_q.push_back({1'b0, 8'hBB});
        mexp_q.push_back({1'b1, 8'hAA});
        m_d_in    = 32'hDDCCBBAA;
        m_empty_n = 1'b1;
        @(negedge clk);
        checkOutput("msb_deq", 32'(m_deq), 32'd1);
        tick();
        m_empty_n = 1'b0;
        repeat (6) tick();
        checkOutput("msb_busy_end", 32'(m_busy), 32'd0);

        checkOutput("scoreboard_drained",     32'(exp_q.size()),  32'd0);
        checkOutput("msb_scoreboard_drained", 32'(mexp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
